// File: rtl/mmio_bus_pkg.sv
// Shared definitions for the 12-bit mmio peripheral bus: opcodes, bridge
// FSM states, address field widths and peripheral select codes.
package mmio_bus_pkg;

    localparam int PSEL_W = 4;
    localparam int REG_W  = 8;
    localparam int ADDR_W = PSEL_W + REG_W;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    // Peripheral select values for addr[11:8]
    localparam logic [PSEL_W-1:0] PSEL_BASIC_IO = 4'h0;
    localparam logic [PSEL_W-1:0] PSEL_KEYPAD   = 4'h1;
    localparam logic [PSEL_W-1:0] PSEL_SOUND    = 4'h2;
    localparam logic [PSEL_W-1:0] PSEL_VGATERM  = 4'h3;
    localparam logic [PSEL_W-1:0] PSEL_PS2      = 4'h4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_ARG   = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4,
        ST_RWAIT = 3'd5,
        ST_RSP   = 3'd6
    } bridge_state_e;

endpackage

// File: rtl/mmio_cmd_bridge.sv
// Byte-stream command bridge: parses write / burst-read commands from a
// valid/ready byte input and acts as an initiator on the mmio bus, returning
// read data as a valid/ready byte stream.
module mmio_cmd_bridge
    import mmio_bus_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_data,
    output logic              re,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data_write,
    input  logic [7:0]        data_read,
    output logic              busy,
    output logic              err
);

    bridge_state_e     state_q, state_d;
    logic              rdy_en_q, rdy_en_d;     // keeps cmd_ready low through reset
    logic              is_rd_q, is_rd_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d; // command address being assembled
    logic [ADDR_W-1:0] addr_q, addr_d;         // address presented on the bus
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [1:0]        wait_q, wait_d;
    logic              err_q, err_d;

    logic       cmd_fire;
    logic [1:0] opcode;
    logic [8:0] cnt_dec;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign opcode   = cmd_data[7:6];
    assign cnt_dec  = cnt_q - 9'd1;

    // Strobes and rsp_valid decode straight from state so reset kills them at once
    assign re         = (state_q == ST_READ);
    assign we         = (state_q == ST_WRITE);
    assign rsp_valid  = (state_q == ST_RSP);
    assign busy       = (state_q != ST_IDLE);
    assign cmd_ready  = rdy_en_q & ((state_q == ST_IDLE) | (state_q == ST_ADDR) |
                                    (state_q == ST_ARG));
    assign addr       = addr_q;
    assign data_write = wdata_q;
    assign rsp_data   = rdata_q;
    assign err        = err_q;

    // Next-state logic: command parse, strobe sequencing and burst bookkeeping
    always_comb begin
        state_d    = state_q;
        rdy_en_d   = 1'b1;
        is_rd_d    = is_rd_q;
        cmd_addr_d = cmd_addr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    if (opcode == OP_WRITE || opcode == OP_READ) begin
                        is_rd_d                        = (opcode == OP_READ);
                        cmd_addr_d[ADDR_W-1:REG_W]     = cmd_data[PSEL_W-1:0];
                        state_d                        = ST_ADDR;
                    end else begin
                        err_d = 1'b1;   // illegal opcode: byte dropped
                    end
                end
            end
            ST_ADDR: begin
                if (cmd_fire) begin
                    cmd_addr_d[REG_W-1:0] = cmd_data;
                    state_d               = ST_ARG;
                end
            end
            ST_ARG: begin
                if (cmd_fire) begin
                    addr_d = cmd_addr_q;
                    if (is_rd_q) begin
                        cnt_d   = (cmd_data == 8'd0) ? 9'd256 : {1'b0, cmd_data};
                        state_d = ST_READ;
                    end else begin
                        wdata_d = cmd_data;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_READ: begin
                wait_d  = 2'(RD_LATENCY - 1);
                state_d = ST_RWAIT;
            end
            ST_RWAIT: begin
                if (wait_q == 2'd0) begin
                    rdata_d = data_read;
                    state_d = ST_RSP;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    cnt_d = cnt_dec;
                    if (cnt_dec == 9'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Register byte wraps; peripheral select is fixed for the burst
                        cmd_addr_d = {cmd_addr_q[ADDR_W-1:REG_W], cmd_addr_q[REG_W-1:0] + 8'd1};
                        addr_d     = {cmd_addr_q[ADDR_W-1:REG_W], cmd_addr_q[REG_W-1:0] + 8'd1};
                        state_d    = ST_READ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rdy_en_q   <= 1'b0;
            is_rd_q    <= 1'b0;
            cmd_addr_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            wait_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdy_en_q   <= rdy_en_d;
            is_rd_q    <= is_rd_d;
            cmd_addr_q <= cmd_addr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_mmio_cmd_bridge.sv
// Directed bench for mmio_cmd_bridge with a simple mmio read model
// (data = addr[7:0] ^ 0x39, latched on the re edge).
module tb_mmio_cmd_bridge;
    import mmio_bus_pkg::*;

    localparam int RD_LATENCY = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_data = 8'h00;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic        re, we;
    logic [11:0] addr;
    logic [7:0]  data_write;
    logic [7:0]  data_read = 8'h00;
    logic        busy, err;

    int vec_cnt = 0;
    int err_cnt = 0;

    mmio_cmd_bridge #(.RD_LATENCY(RD_LATENCY)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .re(re), .we(we), .addr(addr), .data_write(data_write),
        .data_read(data_read), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // mmio model: latch read data on the re edge
    always @(posedge clk) if (re) data_read <= addr[7:0] ^ 8'h39;

    // Bus monitor sampled on the falling edge
    int          cyc = 0;
    int          re_cnt = 0, we_cnt = 0, viol = 0;
    int          re_cyc = 0, rise_cyc = 0;
    logic        prev_re = 1'b0, prev_we = 1'b0, prev_rv = 1'b0;
    logic [11:0] re_addr[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (re) begin re_cnt++; re_cyc = cyc; re_addr.push_back(addr); end
        if (we) we_cnt++;
        if ((re && we) || (re && prev_re) || (we && prev_we)) viol++;
        if (rsp_valid && !prev_rv) rise_cyc = cyc;
        prev_re = re; prev_we = we; prev_rv = rsp_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = b;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (!cmd_ready) chk("cmd_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0); send_byte(b1); send_byte(b2);
    endtask

    task automatic get_rsp(output logic [7:0] d);
        int n = 0;
        @(negedge clk);
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
        d = rsp_data;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1);
    end

    initial begin
        logic [7:0]  d, d0;
        logic [11:0] a;
        int          rc, wc;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outputs", {cmd_ready, rsp_valid, re, we, busy, err}, 6'b0);
        chk("rst_addr_data", {addr, data_write, rsp_data}, 28'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", cmd_ready, 1'b1);

        // Write
        send_cmd(8'h40, 8'h12, 8'hA5);
        @(negedge clk);
        chk("wr_we", we, 1'b1);
        chk("wr_addr", addr, 12'h012);
        chk("wr_data", data_write, 8'hA5);
        repeat (3) @(negedge clk);
        chk("wr_we_cnt", we_cnt, 1);
        chk("wr_no_re", re_cnt, 0);
        chk("wr_idle", busy, 1'b0);

        // Single read
        re_addr.delete();
        send_cmd(8'h82, 8'h05, 8'h01);
        get_rsp(d);
        chk("rd_data", d, 8'h3C);
        chk("rd_addr", re_addr[0], 12'h205);
        chk("rd_latency", rise_cyc - re_cyc, RD_LATENCY + 1);
        chk("rd_re_cnt", re_cnt, 1);

        // Wrapping burst
        re_addr.delete();
        send_cmd(8'h83, 8'hFE, 8'h03);
        get_rsp(d); chk("wrap_d0", d, 8'hC7);
        get_rsp(d); chk("wrap_d1", d, 8'hC6);
        get_rsp(d); chk("wrap_d2", d, 8'h39);
        chk("wrap_n", re_addr.size(), 3);
        chk("wrap_a0", re_addr[0], 12'h3FE);
        chk("wrap_a1", re_addr[1], 12'h3FF);
        chk("wrap_a2", re_addr[2], 12'h300);
        repeat (2) @(negedge clk);
        chk("wrap_idle", busy, 1'b0);

        // Full 256-beat burst with a stall on beat 10
        rc = re_cnt;
        send_cmd(8'h80, 8'h00, 8'h00);
        for (int i = 0; i < 256; i++) begin
            if (i == 10) begin
                int n = 0;
                @(negedge clk);
                while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
                d0 = rsp_data;
                wc = re_cnt;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_data", rsp_data, d0);
                    chk("stall_valid", rsp_valid, 1'b1);
                end
                chk("stall_no_re", re_cnt, wc);
            end
            get_rsp(d);
            chk("full_data", d, 8'(i) ^ 8'h39);
        end
        repeat (3) @(negedge clk);
        chk("full_re_cnt", re_cnt - rc, 256);
        chk("full_last_addr", addr, 12'h0FF);
        chk("full_idle", busy, 1'b0);

        // Illegal opcode, then a normal write
        send_byte(8'hC0);
        @(negedge clk);
        chk("ill_err", err, 1'b1);
        chk("ill_idle", busy, 1'b0);
        @(negedge clk);
        chk("ill_err_pulse", err, 1'b0);
        send_cmd(8'h40, 8'h00, 8'h11);
        @(negedge clk);
        chk("ill_wr_we", we, 1'b1);
        chk("ill_wr_addr", addr, 12'h000);
        chk("ill_wr_data", data_write, 8'h11);

        // Reset during RWAIT
        send_cmd(8'h81, 8'h00, 8'h02);
        begin
            int n = 0;
            @(negedge clk);
            while (!re && n < 20) begin @(negedge clk); n++; end
            chk("rst_mid_re_seen", re, 1'b1);
        end
        @(negedge clk);
        chk("rst_mid_in_rwait", {busy, re, rsp_valid}, 3'b100);
        rc = re_cnt; wc = we_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_async", {re, we, rsp_valid, busy, cmd_ready}, 5'b0);
        chk("rst_mid_addr", {addr, data_write, rsp_data}, 28'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_mid_no_re", re_cnt, rc);
        chk("rst_mid_no_we", we_cnt, wc);
        chk("rst_mid_idle", busy, 1'b0);

        // Fresh command after reset
        re_addr.delete();
        send_cmd(8'h84, 8'h10, 8'h01);
        get_rsp(d);
        chk("post_rst_data", d, 8'h29);
        chk("post_rst_addr", re_addr[0], {PSEL_PS2, 8'h10});

        chk("strobe_rules", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mmio_cmd_bridge.md
# mmio_cmd_bridge

Byte-stream command bridge acting as the initiator on the 12-bit mmio peripheral bus, the other end of the mmio decoder. It accepts write and burst-read commands over a valid/ready byte input, drives `re`/`we`/`addr`/`data_write` toward the mmio block, and returns read bytes over a valid/ready byte output. It sits between a host link (UART/debug port) and the mmio block, as a second bus master alongside the CPU; arbitration with the CPU is external.

## Interface
- `RD_LATENCY`, 1: cycles from the `re` cycle until `data_read` holds the addressed data (mmio latches on the `re` edge). Legal values are 1..4.
- `clk`  in  1  system clock (100 MHz)
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command byte valid
- `cmd_ready`  out  1  bridge accepts the command byte
- `cmd_data`  in  8  command byte
- `rsp_valid`  out  1  read response byte valid
- `rsp_ready`  in  1  sink accepts the response byte
- `rsp_data`  out  8  read response byte
- `re`  out  1  mmio read strobe, single cycle
- `we`  out  1  mmio write strobe, single cycle
- `addr`  out  12  mmio address: [11:8] selects the peripheral, [7:0] selects the register
- `data_write`  out  8  mmio write data
- `data_read`  in  8  mmio latched read data
- `busy`  out  1  high whenever state is not IDLE
- `err`  out  1  one-cycle pulse when an illegal opcode is dropped

## Operation
- Command format:
  - Byte 0: opcode[7:6], addr[11:8] in [3:0]. Bits [5:4] are ignored.
  - Byte 1: addr[7:0].
  - Byte 2 for a write (opcode 2'b01): write data.
  - Byte 2 for a read (opcode 2'b10): count N. N=0 means 256 reads.
  - Opcodes 2'b00 and 2'b11 are illegal. The byte is consumed, `err` pulses, and the state stays IDLE.
- FSM states:
  - IDLE: accept byte 0, then go to ADDR.
  - ADDR: accept addr[7:0], then go to ARG.
  - ARG: accept byte 2. A write goes to WRITE; a read loads the counter and goes to READ.
  - WRITE: `we`=1 for one cycle, then IDLE.
  - READ: `re`=1 for one cycle, then RWAIT.
  - RWAIT: wait RD_LATENCY cycles, capture `data_read` into `rsp_data`, then go to RSP.
  - RSP: hold `rsp_valid` until `rsp_ready`. On the handshake, decrement the counter and increment addr[7:0]. Go to READ if the count is not exhausted, otherwise IDLE.
- `cmd_ready`=1 only in IDLE, ADDR and ARG. A byte is consumed on `cmd_valid & cmd_ready`.
- Burst address arithmetic:
  - addr[7:0] increments modulo 256, so 0xFF is followed by 0x00.
  - addr[11:8] never changes during a burst.
- Counter: 9 bits. Load value is N, or 256 when N=0. The burst ends when the post-decrement count is 0.
- `addr` and `data_write` are registered. They hold their last values outside strobes.
- `re` and `we` are never high simultaneously, and each is never high for two consecutive cycles.

## Timing
- Reset values: state IDLE, counter 0.
  - `cmd_ready`=0 while `rst_n`=0; it rises the first cycle after release.
  - All other outputs (`rsp_valid`, `rsp_data`, `re`, `we`, `addr`, `data_write`, `busy`, `err`) are 0.
- Write: byte 2 is accepted at edge E. `we`, `addr` and `data_write` are valid in cycle E+1. IDLE is reached at E+2.
- Read beat:
  - The `re` cycle is T.
  - `data_read` is sampled at the end of cycle T+RD_LATENCY.
  - `rsp_valid` rises in T+RD_LATENCY+1.
  - Minimum beat with `rsp_ready` tied high is RD_LATENCY+2 cycles.
- Backpressure: `rsp_data` is stable while `rsp_valid & ~rsp_ready`. No new `re` is issued until the response handshake completes.
- `err` pulses in the cycle after the illegal byte is accepted.
- `rst_n` asserted mid-operation:
  - `re`, `we` and `rsp_valid` drop immediately (asynchronously).
  - The partial command and any pending response are discarded.
  - No strobe is issued after release until a new complete command arrives.

## Structure
- Shared package `mmio_bus_pkg`:
  - Opcode constants OP_WRITE=2'b01 and OP_READ=2'b10.
  - FSM state enum.
  - Address-field widths (peripheral select 4 bits, register 8 bits).
- The peripheral select constants (basic IO 0x0, keypad 0x1, sound 0x2, vgaterm 0x3, ps2 0x4) also move into `mmio_bus_pkg` for reuse by benches.
- Single module. No sub-module; the counter and FSM are inline.

## Test plan
- Write: bytes 0x40,0x12,0xA5 → exactly one `we` cycle with `addr`=0x012, `data_write`=0xA5; `re` never asserted.
- Single read: bytes 0x82,0x05,0x01 with a mmio model returning 0x3C → one `re` with `addr`=0x205; `rsp_data`=0x3C, `rsp_valid` rises RD_LATENCY+1 cycles after `re`.
- Wrapping burst: bytes 0x83,0xFE,0x03 → `re` at 0x3FE, 0x3FF, 0x300; three responses in order.
- Full and stalled burst:
  - Bytes 0x80,0x00,0x00 → 256 beats.
  - With `rsp_ready` stalled 5 cycles on beat 10, `rsp_data` stays stable and no extra `re` is issued.
- Illegal opcode: byte 0xC0 → `err` one-cycle pulse, state IDLE. The following 0x40,0x00,0x11 executes normally.
- Reset mid-burst: `rst_n` low during RWAIT → all outputs 0 immediately; no `re`/`we` after release until a new command.
